// File: rtl/block1_frame_sequencer.sv
// Frame sequencer for the block-1 conv3x3 -> ReLU -> maxpool datapath.
// Flushes the datapath, streams one raster-order frame out of the input RAM,
// counts pooled results into sequential output-RAM addresses and flags
// surplus or missing pooled outputs.
module block1_frame_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int WIDTH          = 56,
    parameter int HEIGHT         = 56,
    parameter int IN_ADDR_WIDTH  = 12,
    parameter int OUT_ADDR_WIDTH = 10,
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT        = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_hold,
    output logic                      in_rd_en,
    output logic [IN_ADDR_WIDTH-1:0]  in_rd_addr,
    input  logic [DATA_WIDTH-1:0]     in_rd_data_0,
    input  logic [DATA_WIDTH-1:0]     in_rd_data_1,
    input  logic [DATA_WIDTH-1:0]     in_rd_data_2,
    output logic                      pipe_resetn,
    output logic                      pipe_valid_in,
    output logic [DATA_WIDTH-1:0]     pipe_data_0,
    output logic [DATA_WIDTH-1:0]     pipe_data_1,
    output logic [DATA_WIDTH-1:0]     pipe_data_2,
    input  logic                      pool_valid_out,
    output logic                      out_wr_en,
    output logic [OUT_ADDR_WIDTH-1:0] out_wr_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int N_IN   = WIDTH * HEIGHT;
    localparam int N_OUT  = (WIDTH / 2) * (HEIGHT / 2);
    // One extra bit so the counters can hold N_IN / N_OUT without wrapping.
    localparam int RD_W   = IN_ADDR_WIDTH + 1;
    localparam int WR_W   = OUT_ADDR_WIDTH + 1;
    localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [RD_W-1:0]   RD_LAST  = RD_W'(N_IN - 1);
    localparam logic [RD_W-1:0]   RD_FULL  = RD_W'(N_IN);
    localparam logic [WR_W-1:0]   WR_FULL  = WR_W'(N_OUT);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [RD_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [WR_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                error_q, error_d;
    logic                rd_vld_p1_q;

    logic                counting;
    logic                rd_fire;
    logic                wr_fire;

    // Next-state logic: frame FSM, read/write counters, idle watchdog, fault flag.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        flush_cnt_d = flush_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        error_d     = error_q;

        counting = (state_q == S_STREAM) || (state_q == S_DRAIN);
        rd_fire  = (state_q == S_STREAM) && !in_hold;
        wr_fire  = counting && pool_valid_out && (wr_cnt_q < WR_FULL);

        if (rd_fire && (rd_cnt_q != RD_FULL)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        // A pooled result arriving after the frame is already complete is a surplus.
        if (counting && pool_valid_out && !wr_fire) begin
            error_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FLUSH;
                    rd_cnt_d    = '0;
                    wr_cnt_d    = '0;
                    flush_cnt_d = '0;
                    idle_cnt_d  = '0;
                    error_d     = 1'b0;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FL_LAST) begin
                    state_d = S_STREAM;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (rd_fire && (rd_cnt_q == RD_LAST)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pool_valid_out) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (wr_cnt_d == WR_FULL) begin
                    state_d = S_DONE;
                end else if (idle_cnt_d == IDLE_MAX) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            flush_cnt_q <= '0;
            idle_cnt_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            error_q     <= error_d;
        end
    end

    // Stage p0 -> p1: read enable delayed to line up with the RAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p1_q <= 1'b0;
        end else begin
            rd_vld_p1_q <= rd_fire;
        end
    end

    assign in_rd_en      = rd_fire;
    assign in_rd_addr    = rd_cnt_q[IN_ADDR_WIDTH-1:0];
    assign pipe_resetn   = counting;
    assign pipe_valid_in = rd_vld_p1_q;
    assign pipe_data_0   = in_rd_data_0;
    assign pipe_data_1   = in_rd_data_1;
    assign pipe_data_2   = in_rd_data_2;
    assign out_wr_en     = wr_fire;
    assign out_wr_addr   = wr_cnt_q[OUT_ADDR_WIDTH-1:0];
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign error         = error_q;

endmodule

// File: tb/tb_block1_frame_sequencer.sv
// Self-checking bench for block1_frame_sequencer on a 4x4 frame with a
// behavioural environment (input RAM, pooled-output generator) and a
// frame-timeline reference model.
module tb_block1_frame_sequencer;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int IAW  = 4;
    localparam int OAW  = 2;
    localparam int FC   = 2;
    localparam int TO   = 16;
    localparam int NIN  = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    logic           clk = 1'b0;
    logic           reset, start, in_hold, pool_valid_out;
    logic           in_rd_en, pipe_resetn, pipe_valid_in, out_wr_en, busy, done, error;
    logic [IAW-1:0] in_rd_addr;
    logic [OAW-1:0] out_wr_addr;
    logic [DW-1:0]  in_rd_data_0, in_rd_data_1, in_rd_data_2;
    logic [DW-1:0]  pipe_data_0, pipe_data_1, pipe_data_2;

    block1_frame_sequencer #(
        .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .IN_ADDR_WIDTH(IAW),
        .OUT_ADDR_WIDTH(OAW), .FLUSH_CYCLES(FC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_hold(in_hold),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_rd_data_0(in_rd_data_0), .in_rd_data_1(in_rd_data_1), .in_rd_data_2(in_rd_data_2),
        .pipe_resetn(pipe_resetn), .pipe_valid_in(pipe_valid_in),
        .pipe_data_0(pipe_data_0), .pipe_data_1(pipe_data_1), .pipe_data_2(pipe_data_2),
        .pool_valid_out(pool_valid_out), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Input feature-map RAM contents, one array per channel.
    logic [DW-1:0] m0 [NIN];
    logic [DW-1:0] m1 [NIN];
    logic [DW-1:0] m2 [NIN];

    // Model state carried across cycles/frames.
    bit err_m   = 1'b0;
    bit prev_rd = 1'b0;
    int prev_addr = 0;

    // Per-frame observations, set by run_frame.
    int first_rd, last_rd, n_rd, n_wr, n_done, done_cyc, third_wr;

    task automatic fill_mem();
        for (int i = 0; i < NIN; i++) begin
            m0[i] = $urandom();
            m1[i] = $urandom();
            m2[i] = $urandom();
        end
    endtask

    task automatic drive_data();
        if (prev_rd) begin
            in_rd_data_0 = m0[prev_addr];
            in_rd_data_1 = m1[prev_addr];
            in_rd_data_2 = m2[prev_addr];
        end else begin
            in_rd_data_0 = $urandom();
            in_rd_data_1 = $urandom();
            in_rd_data_2 = $urandom();
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_busy"}, 64'(busy), 64'(0));
        check({pfx, "_pipe_resetn"}, 64'(pipe_resetn), 64'(0));
        check({pfx, "_in_rd_en"}, 64'(in_rd_en), 64'(0));
        check({pfx, "_in_rd_addr"}, 64'(in_rd_addr), 64'(0));
        check({pfx, "_pipe_valid_in"}, 64'(pipe_valid_in), 64'(0));
        check({pfx, "_out_wr_en"}, 64'(out_wr_en), 64'(0));
        check({pfx, "_out_wr_addr"}, 64'(out_wr_addr), 64'(0));
        check({pfx, "_done"}, 64'(done), 64'(0));
        check({pfx, "_error"}, 64'(error), 64'(0));
    endtask

    // Idle cycles with noise on hold and pool_valid_out, which must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start          = 1'b0;
            in_hold        = 1'($urandom_range(0, 1));
            pool_valid_out = 1'($urandom_range(0, 1));
            drive_data();
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_pipe_resetn", 64'(pipe_resetn), 64'(0));
            check("idle_in_rd_en", 64'(in_rd_en), 64'(0));
            check("idle_pipe_valid_in", 64'(pipe_valid_in), 64'(prev_rd));
            check("idle_out_wr_en", 64'(out_wr_en), 64'(0));
            check("idle_done", 64'(done), 64'(0));
            check("idle_error", 64'(error), 64'(err_m));
            prev_rd = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // One frame, start high in cycle 0 (sampled at edge 0).
    // mode: 0 = every 2x2 window yields an output, 1 = last output dropped,
    //       2 = five outputs injected during streaming.
    task automatic run_frame(input int mode, input int h_lo, input int h_hi, input int hold_pct,
                             input int lat, input int abort_at, input bit noisy_start);
        bit sched [512];
        int reads, wr, idle;
        bit done_next, fin;
        bit exp_done, flushing, active, streaming, draining, exp_rd, exp_wr;
        int c, p;
        reads = 0; wr = 0; idle = 0; done_next = 0; fin = 0;
        first_rd = -1; last_rd = -1; n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1; third_wr = -1;
        for (int i = 0; i < 512; i++) sched[i] = 1'b0;
        // Spurious datapath outputs while it is still held in reset.
        sched[1] = 1'($urandom_range(0, 1));
        sched[2] = 1'($urandom_range(0, 1));
        if (mode == 2) begin
            for (int i = 0; i < 5; i++) sched[FC + 2 + 3 * i] = 1'b1;
        end
        for (c = 0; c < 400 && !fin; c++) begin
            start          = (c == 0) || (noisy_start && (c == 5 || done_next));
            reset          = (c == abort_at);
            in_hold        = (c >= h_lo && c <= h_hi) || (int'($urandom_range(0, 99)) < hold_pct);
            pool_valid_out = sched[c];
            drive_data();
            @(negedge clk);
            if (abort_at >= 0 && c == abort_at + 1) begin
                check_reset_values("abort");
                err_m   = 1'b0;
                prev_rd = 1'b0;
                fin     = 1'b1;
            end else if (c == 0) begin
                check("start_busy", 64'(busy), 64'(0));
                check("start_error", 64'(error), 64'(err_m));
                check("start_pipe_valid_in", 64'(pipe_valid_in), 64'(prev_rd));
                prev_rd = 1'b0;
                err_m   = 1'b0;
            end else begin
                exp_done  = done_next;
                flushing  = (c <= FC);
                active    = !flushing && !exp_done;
                streaming = active && (reads < NIN);
                draining  = active && (reads == NIN);
                exp_rd    = streaming && !in_hold;
                exp_wr    = active && pool_valid_out && (wr < NOUT);
                check("busy", 64'(busy), 64'(1));
                check("pipe_resetn", 64'(pipe_resetn), 64'(active));
                check("in_rd_en", 64'(in_rd_en), 64'(exp_rd));
                if (exp_rd) check("in_rd_addr", 64'(in_rd_addr), 64'(reads));
                check("pipe_valid_in", 64'(pipe_valid_in), 64'(prev_rd));
                if (prev_rd) begin
                    check("pipe_data_0", 64'(pipe_data_0), 64'(m0[prev_addr]));
                    check("pipe_data_1", 64'(pipe_data_1), 64'(m1[prev_addr]));
                    check("pipe_data_2", 64'(pipe_data_2), 64'(m2[prev_addr]));
                end
                check("out_wr_en", 64'(out_wr_en), 64'(exp_wr));
                if (exp_wr) check("out_wr_addr", 64'(out_wr_addr), 64'(wr));
                check("done", 64'(done), 64'(exp_done));
                check("error", 64'(error), 64'(err_m));

                // Environment: a pixel closing a 2x2 window yields a pooled output lat cycles on.
                if (prev_rd && mode != 2) begin
                    p = prev_addr;
                    if (((p / W) % 2 == 1) && ((p % W) % 2 == 1) && !(mode == 1 && p == NIN - 1))
                        sched[c + lat] = 1'b1;
                end
                prev_rd   = exp_rd;
                prev_addr = reads;
                if (exp_rd) begin
                    if (first_rd < 0) first_rd = c;
                    last_rd = c;
                    reads++;
                    n_rd++;
                end
                if (active && pool_valid_out) begin
                    if (wr < NOUT) begin
                        wr++;
                        n_wr++;
                        if (wr == 3) third_wr = c;
                    end else begin
                        err_m = 1'b1;
                    end
                end
                if (draining) begin
                    idle = pool_valid_out ? 0 : idle + 1;
                    if (wr == NOUT) begin
                        done_next = 1'b1;
                    end else if (idle == TO) begin
                        done_next = 1'b1;
                        err_m     = 1'b1;
                    end
                end
                if (exp_done) begin
                    n_done++;
                    done_cyc  = c;
                    done_next = 1'b0;
                    fin       = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        check("frame_completed_in_budget", 64'(fin), 64'(1));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_hold = 1'b0; pool_valid_out = 1'b0;
        in_rd_data_0 = '0; in_rd_data_1 = '0; in_rd_data_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(3);

        // Plain frame, no hold.
        fill_mem();
        run_frame(0, -1, -1, 0, 3, -1, 1'b0);
        check("t1_first_read_cycle", 64'(first_rd), 64'(FC + 1));
        check("t1_last_read_cycle", 64'(last_rd), 64'(FC + NIN));
        check("t1_writes", 64'(n_wr), 64'(NOUT));
        check("t1_done_pulses", 64'(n_done), 64'(1));
        check("t1_error", 64'(error), 64'(0));
        idle_cycles(3);

        // Hold in cycles 5..7.
        fill_mem();
        run_frame(0, 5, 7, 0, 3, -1, 1'b0);
        check("t2_reads", 64'(n_rd), 64'(NIN));
        check("t2_last_read_cycle", 64'(last_rd), 64'(FC + NIN + 3));
        idle_cycles(3);

        // Last pooled output never arrives: watchdog ends the frame.
        fill_mem();
        run_frame(1, -1, -1, 0, 3, -1, 1'b0);
        check("t3_done_after_third_write", 64'(done_cyc - third_wr), 64'(TO + 1));
        check("t3_writes", 64'(n_wr), 64'(NOUT - 1));
        check("t3_error", 64'(error), 64'(1));
        idle_cycles(4);

        // Five pooled outputs during streaming: the surplus is suppressed.
        fill_mem();
        run_frame(2, -1, -1, 0, 3, -1, 1'b0);
        check("t4_writes", 64'(n_wr), 64'(NOUT));
        check("t4_error", 64'(error), 64'(1));
        idle_cycles(2);

        // Reset in cycle 10, then a clean frame.
        fill_mem();
        run_frame(0, -1, -1, 0, 3, 10, 1'b0);
        check("t5_abort_no_done", 64'(n_done), 64'(0));
        idle_cycles(2);
        run_frame(0, -1, -1, 0, 3, -1, 1'b0);
        check("t5_clean_done", 64'(n_done), 64'(1));
        check("t5_clean_error", 64'(error), 64'(0));
        idle_cycles(2);

        // Start pulsed while busy, with some hold.
        fill_mem();
        run_frame(0, -1, -1, 20, 3, -1, 1'b1);
        check("t6_reads", 64'(n_rd), 64'(NIN));
        check("t6_done_pulses", 64'(n_done), 64'(1));
        idle_cycles(2);

        // Randomised frames: random hold density, latency and dropped outputs.
        for (int f = 0; f < 20; f++) begin
            fill_mem();
            run_frame(int'($urandom_range(0, 1)), -1, -1, int'($urandom_range(0, 50)),
                      int'($urandom_range(1, 4)), -1, 1'($urandom_range(0, 1)));
            check("rand_reads", 64'(n_rd), 64'(NIN));
            check("rand_done_pulses", 64'(n_done), 64'(1));
            idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
